// File: rtl/secded_stream_encoder.sv
// secded_stream_encoder
//   Two-stage systematic Hamming / SECDED encoder with valid/ready handshakes
//   on both sides. It also injects an optional single-bit error and counts
//   the words delivered.
//
//   Codeword layout: c[K-1:0] = data, c[K+R-1:K] = Hamming parity,
//   c[N-1] = overall parity (SECDED mode) or 0 (SEC mode).
//
//   Ports
//     clk, rst_n              clock, synchronous active-low reset
//     in_valid/in_ready       input handshake; in_ready is combinational
//                             from out_ready
//     in_data[K-1:0]          data word
//     secded_en               1 = SECDED, 0 = SEC (captured with the word)
//     inj_en, inj_pos[PW-1:0] flip codeword bit inj_pos (>= N: no flip)
//     out_valid/out_ready     output handshake (registered out_valid)
//     out_code[N-1:0]         registered codeword
//     word_cnt[15:0]          delivered-word count, saturating at 0xFFFF
module secded_stream_encoder #(
  parameter  int K  = 8,
  // smallest r with 2^r >= K+r+1, over the supported range K = 2..57
  localparam int R  = (K <= 4) ? 3 : (K <= 11) ? 4 : (K <= 26) ? 5 : 6,
  localparam int N  = K + R + 1,
  localparam int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_data,
  input  logic          secded_en,
  input  logic          inj_en,
  input  logic [PW-1:0] inj_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_code,
  output logic [15:0]   word_cnt
);

  // Hamming position of data bit i: the i-th integer >= 3 that is not a
  // power of two. It is only ever called with constant loop indices, so it
  // folds to wiring.
  function automatic logic [R-1:0] dpos(int i);
    logic [R-1:0] p;
    int           n;
    p = '0;
    n = 0;
    for (int c = 3; c < 128; c++) begin
      if ((c & (c - 1)) != 0) begin
        if (n == i) p = R'(c);
        n++;
      end
    end
    return p;
  endfunction

  logic [2:1]    vld_q, vld_d;   // [1] = S1 holds a word, [2] = S2 holds a word
  logic [K-1:0]  s1_data_q;
  logic          s1_sec_q, s1_inj_q;
  logic [PW-1:0] s1_pos_q;
  logic [N-1:0]  s2_code_q;
  logic [15:0]   cnt_q, cnt_d;
  logic          in_fire, out_fire, s1_adv;
  logic [R-1:0]  par;
  logic [N-1:0]  code;

  assign in_ready = rst_n & (~vld_q[1] | ~vld_q[2] | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_q[2] & out_ready;
  assign s1_adv   = vld_q[1] & (~vld_q[2] | out_ready);

  // Encode the S1 word. Parity bit j is the XOR of the data bits whose
  // position has bit j set.
  always_comb begin
    par = '0;
    for (int i = 0; i < K; i++)
      if (s1_data_q[i]) par = par ^ dpos(i);
    code = {1'b0, par, s1_data_q};
    if (s1_sec_q) code[N-1] = ^code[N-2:0];
    // A shift by >= N moves the 1 out of the mask, which gives "no flip" for
    // out-of-range positions without a separate compare.
    if (s1_inj_q) code = code ^ (N'(1) << s1_pos_q);
  end

  always_comb begin
    vld_d = vld_q;
    if (s1_adv)        vld_d[2] = 1'b1;
    else if (out_fire) vld_d[2] = 1'b0;
    if (in_fire)       vld_d[1] = 1'b1;
    else if (s1_adv)   vld_d[1] = 1'b0;
    cnt_d = cnt_q;
    if (out_fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      s1_data_q <= '0;
      s1_sec_q  <= 1'b0;
      s1_inj_q  <= 1'b0;
      s1_pos_q  <= '0;
      s2_code_q <= '0;
      cnt_q     <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (in_fire) begin
        s1_data_q <= in_data;
        s1_sec_q  <= secded_en;
        s1_inj_q  <= inj_en;
        s1_pos_q  <= inj_pos;
      end
      if (s1_adv) s2_code_q <= code;
    end
  end

  assign out_valid = vld_q[2];
  assign out_code  = s2_code_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_secded_stream_encoder.sv
module tb_secded_stream_encoder;
  localparam int K = 8, R = 4, N = 13, PW = 4;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, secded_en, inj_en, out_valid, out_ready;
  logic [K-1:0]  in_data;
  logic [PW-1:0] inj_pos;
  logic [N-1:0]  out_code;
  logic [15:0]   word_cnt;
  int            checks = 0, errors = 0;

  secded_stream_encoder #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .secded_en(secded_en), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoder. The classic Hamming view: the parity field equals the
  // XOR of the positions of all set data bits, so the syndrome of a clean
  // word is zero.
  function automatic logic [N-1:0] ref_code(logic [K-1:0] d, logic sd, logic ie, logic [PW-1:0] ip);
    int pos, syn;
    logic [N-1:0] c;
    pos = 3;
    syn = 0;
    for (int i = 0; i < K; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) syn = syn ^ pos;
      pos++;
    end
    c = '0;
    c[K-1:0] = d;
    c[K+R-1:K] = syn[R-1:0];
    if (sd) c[N-1] = ^c[N-2:0];
    if (ie && ip < N) c[ip] = ~c[ip];
    return c;
  endfunction

  // Scoreboard: pend holds the words in flight. Its size is the expected
  // buffer occupancy.
  logic [N-1:0] pend[$], got_log[$], exp_log[$];
  logic [N-1:0] mon_e, code_prev;
  int           rdy_bad = 0, stab_bad = 0, n_out = 0;
  bit           log_en = 1'b1, stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      stall_prev = 1'b0;
    end else begin
      if (in_ready !== !(pend.size() == 2 && !out_ready)) rdy_bad++;
      if (stall_prev && (out_valid !== 1'b1 || out_code !== code_prev)) stab_bad++;
      if (out_valid && out_ready) begin
        n_out++;
        mon_e = 'x;
        if (pend.size() > 0) mon_e = pend.pop_front();
        if (log_en) begin
          got_log.push_back(out_code);
          exp_log.push_back(mon_e);
        end
      end
      if (in_valid && in_ready) pend.push_back(ref_code(in_data, secded_en, inj_en, inj_pos));
      stall_prev = out_valid && !out_ready;
      code_prev = out_code;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    secded_en = 1'b1; inj_en = 1'b0; inj_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_log.delete(); exp_log.delete();
    rdy_bad = 0; stab_bad = 0; n_out = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    secded_en = 1'b1; inj_en = 1'b0; inj_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_code !== '0) begin errors++; $display("FAIL reset_out_code got %h exp 0", out_code); end
    checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL reset_word_cnt got %h exp 0", word_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask

  // Three back-to-back words with out_ready=1. Word i must appear right after
  // the edge that follows its accept edge.
  task automatic test_directed(input string nm, input logic sd, input logic [2:0][K-1:0] d,
                               input logic [2:0] ie, input logic [2:0][PW-1:0] ip,
                               input logic [2:0][N-1:0] ev);
    apply_reset();
    out_ready = 1'b1;
    secded_en = sd;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      if (i < 3) begin
        in_data = d[i]; inj_en = ie[i]; inj_pos = ip[i];
      end
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_code !== ev[i-1]) begin
          errors++;
          $display("FAIL %s_word%0d got v=%b %h exp v=1 %h", nm, i - 1, out_valid, out_code, ev[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_idle got v=%b exp 0", nm, out_valid); end
    checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL %s_word_cnt got %0d exp 3", nm, word_cnt); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] sent[$];
    int idx = 0, cyc = 0;
    bit acc;
    apply_reset();
    while (idx < 16 && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = K'(8'h10 + idx);
      secded_en = 1'($urandom_range(0, 1));
      inj_en    = 1'($urandom_range(0, 1));
      inj_pos   = PW'($urandom_range(0, 15));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent.push_back(ref_code(in_data, secded_en, inj_en, inj_pos));
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (idx != 16) begin errors++; $display("FAIL bp_accept_budget got %0d exp 16", idx); end
    checks++; if (got_log.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got_log.size()); end
    for (int i = 0; i < got_log.size() && i < sent.size(); i++) begin
      checks++;
      if (got_log[i] !== sent[i]) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_log[i], sent[i]); end
    end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL bp_in_ready got %0d bad cycles exp 0", rdy_bad); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stall_stable got %0d bad cycles exp 0", stab_bad); end
    checks++; if (word_cnt !== 16'd16) begin errors++; $display("FAIL bp_word_cnt got %0d exp 16", word_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = K'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (word_cnt !== 16'd3) begin errors++; $display("FAIL rm_pre_cnt got %0d exp 3", word_cnt); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_data = 8'h5A;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_full_out_valid got %b exp 1", out_valid); end
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_rst_in_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_rst_out_valid got %b exp 0", out_valid); end
    checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rm_rst_word_cnt got %0d exp 0", word_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_release_in_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d got v=%b exp 0", i, out_valid); end
    end
    checks++; if (got_log.size() != 3) begin errors++; $display("FAIL rm_delivered got %0d exp 3", got_log.size()); end
  endtask

  task automatic test_sweep();
    logic [N-1:0] sent[$];
    apply_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        in_data = K'(v); secded_en = 1'(m);
        inj_en = ($urandom_range(0, 3) == 0); inj_pos = PW'($urandom_range(0, 15));
        sent.push_back(ref_code(in_data, secded_en, inj_en, inj_pos));
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_log.size() != 512) begin errors++; $display("FAIL sweep_count got %0d exp 512", got_log.size()); end
    for (int i = 0; i < got_log.size() && i < sent.size(); i++) begin
      checks++;
      if (got_log[i] !== sent[i]) begin errors++; $display("FAIL sweep_word%0d got %h exp %h", i, got_log[i], sent[i]); end
    end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL sweep_in_ready got %0d bad cycles exp 0", rdy_bad); end
  endtask

  task automatic test_saturation();
    int cyc = 0;
    apply_reset();
    log_en = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; inj_en = 1'b0;
    while (n_out < 65537 && cyc < 70000) begin
      in_data = K'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (n_out == 65534) begin
        checks++; if (word_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", word_cnt); end
      end
    end
    checks++; if (n_out < 65537) begin errors++; $display("FAIL sat_budget got %0d exp 65537", n_out); end
    checks++; if (word_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", word_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (word_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold2 got %h exp ffff", word_cnt); end
    in_valid = 1'b0;
    log_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed("secded", 1'b1, {8'hFF, 8'h01, 8'h00}, 3'b000, {4'd0, 4'd0, 4'd0},
                  {13'h03FF, 13'h1301, 13'h0000});
    test_directed("sec", 1'b0, {8'hFF, 8'h01, 8'h00}, 3'b000, {4'd0, 4'd0, 4'd0},
                  {13'h03FF, 13'h0301, 13'h0000});
    test_directed("inject", 1'b1, {8'h01, 8'h01, 8'h01}, 3'b111, {4'd13, 4'd12, 4'd0},
                  {13'h1301, 13'h0301, 13'h1300});
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
